lifo_arbiter: RTL and testbench
===============================

# lifo_arbiter

Shares one LIFO instance between two requesting clients. Each client posts a push or pop request; the arbiter picks one per slot (round-robin by default), drives the LIFO `write`/`read`/`datain` strobes, tracks occupancy, and routes popped data back to the client that asked for it. It sits between the client logic and the LIFO and is the only block that drives the LIFO control inputs.

## Interface
- `WIDTH`, 8, data width; equals LIFO data width
- `DEPTH`, 8, LIFO capacity in entries; equals the LIFO instance depth
- `CNTW`, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; holds block in reset while 0
- `c0_req`, `c1_req`  in  1  client request; held until acked
- `c0_op`, `c1_op`  in  1  1 = push, 0 = pop; stable while req high
- `c0_din`, `c1_din`  in  WIDTH  push data; stable while req high
- `c0_ack`, `c1_ack`  out  1  one-cycle pulse: request issued to LIFO
- `c0_rvalid`, `c1_rvalid`  out  1  one-cycle pulse: pop data valid
- `c0_rdata`, `c1_rdata`  out  WIDTH  popped data, valid with rvalid
- `c0_err`, `c1_err`  out  1  one-cycle pulse: pop timed out
- `lifo_write`, `lifo_read`  out  1  LIFO strobes; never both 1
- `lifo_datain`  out  WIDTH  data to LIFO
- `lifo_dataout`  in  WIDTH  data from LIFO
- `lifo_val`  in  1  LIFO output valid
- `lifo_full`  in  1  LIFO full flag
- `count`  out  CNTW  current occupancy
- `empty`  out  1  count == 0

## Operation
- FSM states: IDLE, PUSH, POP, PWAIT.
- Eligibility in IDLE: push eligible if `count < DEPTH` and `lifo_full == 0`; pop eligible if `count > 0`. Ineligible requests stay pending, unacked, and never block the other client.
- IDLE: if no eligible request, stay. Else pick winner (see arbitration), register `lifo_datain` = winner din, set `lifo_write` (push → PUSH) or `lifo_read` (pop → POP), pulse winner ack.
- PUSH: strobe high this cycle; at its end `count` += 1, → IDLE.
- POP: strobe high this cycle; at its end `count` -= 1, timeout counter = 0, → PWAIT.
- PWAIT: when `lifo_val == 1`, register `lifo_dataout` into owner's rdata, pulse owner's rvalid next cycle, → IDLE. If `lifo_val` has not been seen after 4 PWAIT cycles, pulse owner's err, → IDLE; count is not restored.
- Arbitration (default): register `last` (reset = 1). Both eligible → grant client != `last`; single eligible → grant it. `last` updates on every grant.
- rdata of a client holds its last popped value until its next rvalid; rdata of the other client is unaffected.
- `count` saturates: never exceeds DEPTH, never below 0 (guaranteed by eligibility).

## Timing
- Reset (`reset` = 0): state IDLE; all strobes, acks, rvalids, errs = 0; `lifo_datain`, rdata = 0; `count` = 0; `empty` = 1; `last` = 1. Asserting reset mid-operation aborts any PUSH/POP/PWAIT with no ack, rvalid or err emitted; the LIFO is reset by the same signal.
- All outputs registered; `empty` derived from registered `count`.
- Push: request seen in IDLE cycle N → ack + `lifo_write` in N+1 → IDLE in N+2. Max push rate 1 per 2 cycles.
- Pop: request in N → ack + `lifo_read` in N+1 → PWAIT from N+2; `lifo_val` seen in cycle M → rvalid + rdata in M+1 → IDLE in M+1 (next request sampled in M+1).
- Client must drop req (or change op) in the cycle after ack; a req still high in the next IDLE is a new request.
- `count` changes at the end of the strobe cycle, so the next IDLE sees the updated value.

## Configuration
- `LIFO_ARB_FIXED_PRIO_EN` defined: fixed priority, client 0 always wins when both eligible; `last` not implemented.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset, client 0 pushes 8'h05 → `c0_ack` and `lifo_write` high 1 cycle after req, `lifo_datain` = 8'h05, `count` = 1, `empty` = 0.
- Client 0 pushes 8'h04, 8'h03 after reset; client 1 pops twice → `c1_rdata` = 8'h03 then 8'h04 with `c1_rvalid` pulses, `count` back to 0.
- Both clients push continuously (8'hA0/8'hB0) → acks alternate c0, c1, c0…; with `LIFO_ARB_FIXED_PRIO_EN`, only c0 acked until it drops req.
- Fill to `count` = 8 by pushing; c0 keeps pushing while c1 pops → c0 never acked while full, c1 pop acked, then c0 push acked.
- Pop request with `count` = 0 → no ack, no `lifo_read`; LIFO tied `lifo_val` = 0 after a legal pop → owner err pulse after 4 PWAIT cycles, FSM back to IDLE.
- `reset` = 0 during PWAIT → all outputs 0 immediately, `count` = 0, no rvalid after release.

Source files
------------

// File: rtl/lifo_arbiter.sv
// Two-client arbiter in front of a single LIFO: grants push/pop requests, drives LIFO strobes,
// tracks occupancy and returns popped data. Define LIFO_ARB_FIXED_PRIO_EN for fixed priority.
module lifo_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CNTW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             c0_req,
  input  logic             c1_req,
  input  logic             c0_op,
  input  logic             c1_op,
  input  logic [WIDTH-1:0] c0_din,
  input  logic [WIDTH-1:0] c1_din,
  output logic             c0_ack,
  output logic             c1_ack,
  output logic             c0_rvalid,
  output logic             c1_rvalid,
  output logic [WIDTH-1:0] c0_rdata,
  output logic [WIDTH-1:0] c1_rdata,
  output logic             c0_err,
  output logic             c1_err,
  output logic             lifo_write,
  output logic             lifo_read,
  output logic [WIDTH-1:0] lifo_datain,
  input  logic [WIDTH-1:0] lifo_dataout,
  input  logic             lifo_val,
  input  logic             lifo_full,
  output logic [CNTW-1:0]  count,
  output logic             empty
);

  localparam logic [CNTW-1:0] DepthC = CNTW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPush, StPop, StPwait} state_e;

  state_e           state_q, state_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [1:0]       tmo_q, tmo_d;
  logic             owner_q, owner_d;
  logic             write_q, write_d, read_q, read_d;
  logic [WIDTH-1:0] datain_q, datain_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic             err0_q, err0_d, err1_q, err1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
`ifndef LIFO_ARB_FIXED_PRIO_EN
  logic             last_q, last_d;
`endif

  logic push_ok, pop_ok, elig0, elig1, gnt1, win_op;

  always_comb begin
    push_ok = (count_q < DepthC) && !lifo_full;
    pop_ok  = (count_q != '0);
    elig0   = c0_req && (c0_op ? push_ok : pop_ok);
    elig1   = c1_req && (c1_op ? push_ok : pop_ok);
`ifdef LIFO_ARB_FIXED_PRIO_EN
    gnt1    = elig1 && !elig0;
`else
    // On contention the client that did not win last time gets the slot.
    gnt1    = elig1 && (!elig0 || !last_q);
`endif
    win_op  = gnt1 ? c1_op : c0_op;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tmo_d     = tmo_q;
    owner_d   = owner_q;
    datain_d  = datain_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    write_d   = 1'b0;
    read_d    = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (elig0 || elig1) begin
          owner_d  = gnt1;
          datain_d = gnt1 ? c1_din : c0_din;
          ack0_d   = !gnt1;
          ack1_d   = gnt1;
`ifndef LIFO_ARB_FIXED_PRIO_EN
          last_d   = gnt1;
`endif
          if (win_op) begin
            write_d = 1'b1;
            state_d = StPush;
          end else begin
            read_d  = 1'b1;
            state_d = StPop;
          end
        end
      end
      StPush: begin
        if (count_q != DepthC) count_d = count_q + 1'b1;
        state_d = StIdle;
      end
      StPop: begin
        if (count_q != '0) count_d = count_q - 1'b1;
        tmo_d   = 2'd0;
        state_d = StPwait;
      end
      StPwait: begin
        if (lifo_val) begin
          if (owner_q) begin
            rdata1_d  = lifo_dataout;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = lifo_dataout;
            rvalid0_d = 1'b1;
          end
          state_d = StIdle;
        end else if (tmo_q == 2'd3) begin
          // Popped entry is considered lost; occupancy stays decremented.
          err0_d  = !owner_q;
          err1_d  = owner_q;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      tmo_q     <= 2'd0;
      owner_q   <= 1'b0;
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      datain_q  <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      owner_q   <= owner_d;
      write_q   <= write_d;
      read_q    <= read_d;
      datain_q  <= datain_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifndef LIFO_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign c0_ack      = ack0_q;
  assign c1_ack      = ack1_q;
  assign c0_rvalid   = rvalid0_q;
  assign c1_rvalid   = rvalid1_q;
  assign c0_rdata    = rdata0_q;
  assign c1_rdata    = rdata1_q;
  assign c0_err      = err0_q;
  assign c1_err      = err1_q;
  assign lifo_write  = write_q;
  assign lifo_read   = read_q;
  assign lifo_datain = datain_q;
  assign count       = count_q;
  assign empty       = (count_q == '0);

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed self-checking bench for lifo_arbiter with a small behavioural LIFO attached.
module tb_lifo_arbiter;

`ifdef LIFO_ARB_FIXED_PRIO_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       c0_req = 0, c1_req = 0, c0_op = 0, c1_op = 0;
  logic [7:0] c0_din = 0, c1_din = 0;
  logic       c0_ack, c1_ack, c0_rvalid, c1_rvalid, c0_err, c1_err;
  logic [7:0] c0_rdata, c1_rdata;
  logic       lifo_write, lifo_read, lifo_val, lifo_full;
  logic [7:0] lifo_datain, lifo_dataout;
  logic [3:0] count;
  logic       empty;

  int n_total = 0;
  int n_pass  = 0;

  lifo_arbiter #(.WIDTH(8), .DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .c0_req(c0_req), .c1_req(c1_req), .c0_op(c0_op), .c1_op(c1_op),
    .c0_din(c0_din), .c1_din(c1_din),
    .c0_ack(c0_ack), .c1_ack(c1_ack), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .c0_rdata(c0_rdata), .c1_rdata(c1_rdata), .c0_err(c0_err), .c1_err(c1_err),
    .lifo_write(lifo_write), .lifo_read(lifo_read), .lifo_datain(lifo_datain),
    .lifo_dataout(lifo_dataout), .lifo_val(lifo_val), .lifo_full(lifo_full),
    .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  // Stand-in LIFO: data valid the cycle after a read; val_dis models a stuck LIFO.
  logic [7:0] stk [8];
  int         sp;
  bit         val_dis = 1'b0;
  assign lifo_full = (sp == 8);

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp           <= 0;
      lifo_val     <= 1'b0;
      lifo_dataout <= 8'h00;
    end else begin
      lifo_val <= 1'b0;
      if (lifo_write && sp < 8) begin
        stk[sp] <= lifo_datain;
        sp      <= sp + 1;
      end else if (lifo_read && sp > 0) begin
        lifo_dataout <= stk[sp-1];
        lifo_val     <= !val_dis;
        sp           <= sp - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic exp1;
    #1 reset = 1'b0;
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_strobes", {lifo_write, lifo_read, c0_ack, c1_ack}, 0);
    chk("rst_datain", lifo_datain, 0);
    chk("rst_rdata", {c0_rdata, c1_rdata}, 0);
    reset = 1'b1;

    // Single push from client 0
    c0_req = 1; c0_op = 1; c0_din = 8'h05;
    tick();
    chk("push_ack_write", {c0_ack, c1_ack, lifo_write, lifo_read}, 4'b1010);
    chk("push_datain", lifo_datain, 8'h05);
    chk("push_count_during", count, 0);
    c0_req = 0;
    tick();
    chk("push_count", count, 1);
    chk("push_empty", empty, 0);
    chk("push_ack_pulse", {c0_ack, lifo_write}, 0);

    // Push 04, 03 then client 1 pops both back in LIFO order
    do_reset();
    c0_req = 1; c0_op = 1; c0_din = 8'h04;
    tick(); c0_req = 0; tick();
    c0_req = 1; c0_din = 8'h03;
    tick(); c0_req = 0; tick();
    chk("two_push_count", count, 2);
    c1_req = 1; c1_op = 0;
    tick();
    chk("pop1_ack_read", {c0_ack, c1_ack, lifo_write, lifo_read}, 4'b0101);
    c1_req = 0;
    tick();
    chk("pop1_count", count, 1);
    tick();
    chk("pop1_rvalid", {c0_rvalid, c1_rvalid}, 2'b01);
    chk("pop1_rdata", c1_rdata, 8'h03);
    c1_req = 1;
    tick();
    chk("pop2_ack", c1_ack, 1);
    c1_req = 0;
    tick();
    chk("pop2_empty", {count, empty}, 5'b00001);
    tick();
    chk("pop2_rvalid", c1_rvalid, 1);
    chk("pop2_rdata", c1_rdata, 8'h04);
    tick();
    chk("pop2_rvalid_pulse", c1_rvalid, 0);
    chk("pop2_rdata_hold", c1_rdata, 8'h04);
    chk("c0_rdata_untouched", c0_rdata, 8'h00);

    // Both clients push continuously until full
    c0_req = 1; c0_op = 1; c0_din = 8'hA0;
    c1_req = 1; c1_op = 1; c1_din = 8'hB0;
    for (int i = 0; i < 8; i++) begin
      exp1 = !Fixed && (i % 2 == 1);
      tick();
      chk($sformatf("rr_ack%0d", i), {c0_ack, c1_ack}, {!exp1, exp1});
      chk($sformatf("rr_data%0d", i), lifo_datain, exp1 ? 8'hB0 : 8'hA0);
      if (i == 7) c1_req = 0;
      tick();
    end
    chk("full_count", count, 8);
    tick();
    chk("full_no_ack0", {c0_ack, lifo_write}, 0);
    tick();
    chk("full_no_ack0_b", {c0_ack, lifo_write}, 0);
    c1_req = 1; c1_op = 0;
    tick();
    chk("full_pop_ack1", {c0_ack, c1_ack, lifo_read}, 3'b011);
    c1_req = 0;
    tick();
    chk("full_pop_count", count, 7);
    tick();
    chk("full_pop_rdata", {c1_rvalid, c1_rdata}, {1'b1, Fixed ? 8'hA0 : 8'hB0});
    tick();
    chk("after_pop_ack0", {c0_ack, lifo_write, lifo_datain}, {2'b11, 8'hA0});
    c0_req = 0;
    tick();
    chk("refill_count", count, 8);

    // Pop on empty stays pending without blocking; then stuck LIFO times out
    do_reset();
    c0_req = 1; c0_op = 0;
    tick(); tick();
    chk("empty_pop_no_ack", {c0_ack, lifo_read}, 0);
    c1_req = 1; c1_op = 1; c1_din = 8'h11;
    tick();
    chk("empty_pop_nonblock", {c0_ack, c1_ack, lifo_write}, 3'b011);
    c1_req = 0;
    val_dis = 1;
    tick();
    tick();
    chk("pend_pop_ack", {c0_ack, lifo_read}, 2'b11);
    c0_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("tmo_wait%0d", i), {c0_err, c0_rvalid}, 0);
    end
    tick();
    chk("tmo_err", {c0_err, c1_err, c0_rvalid}, 3'b100);
    chk("tmo_count", count, 0);
    tick();
    chk("tmo_err_pulse", c0_err, 0);
    c1_req = 1; c1_op = 1; c1_din = 8'h22;
    tick();
    chk("tmo_back_idle", {c1_ack, lifo_write}, 2'b11);
    c1_req = 0;
    tick();

    // Reset while waiting for pop data
    c1_req = 1; c1_op = 0;
    tick();
    chk("pwait_pop_ack", c1_ack, 1);
    c1_req = 0;
    tick();
    #1 reset = 1'b0;
    #1;
    chk("midrst_count", {count, empty}, 5'b00001);
    chk("midrst_strobes", {lifo_write, lifo_read, c0_ack, c1_ack, c1_rvalid, c1_err}, 0);
    chk("midrst_datain", lifo_datain, 0);
    val_dis = 0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("midrst_quiet%0d", i), {c1_rvalid, c1_err, c0_rvalid, c0_err}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
